// File: rtl/bank_router_if.sv
// Packet type shared by the banks and the central router, plus the router's bus interface.
// Bank-side agents (banks/host) use the master modport; bank_router uses slave.
package bank_router_pkg;
    typedef enum logic [1:0] {
        CTRL_DATA = 2'd0,
        CTRL_DONE = 2'd1,
        CTRL_CFG  = 2'd2,
        CTRL_RSVD = 2'd3
    } ctrl_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } addr_t;

    typedef struct packed {
        ctrl_t       ctrl;
        addr_t       addr;
        logic [15:0] data;
    } pkt_t;
endpackage

interface bank_router_if #(
    parameter int NUM_BANKS = 4
);
    logic [NUM_BANKS-1:0]                         from_bank_valid;
    logic [NUM_BANKS-1:0]                         from_bank_ready;
    bank_router_pkg::pkt_t [NUM_BANKS-1:0]        from_bank_pkt;
    logic [NUM_BANKS-1:0]                         to_bank_valid;
    logic [NUM_BANKS-1:0]                         to_bank_ready;
    bank_router_pkg::pkt_t [NUM_BANKS-1:0]        to_bank_pkt;
    logic                                         host_valid;
    logic                                         host_ready;
    bank_router_pkg::pkt_t                        host_pkt;

    modport master (
        output from_bank_valid, from_bank_pkt, to_bank_ready, host_valid, host_pkt,
        input  from_bank_ready, to_bank_valid, to_bank_pkt, host_ready
    );

    modport slave (
        input  from_bank_valid, from_bank_pkt, to_bank_ready, host_valid, host_pkt,
        output from_bank_ready, to_bank_valid, to_bank_pkt, host_ready
    );
endinterface

// File: rtl/bank_router.sv
// Central bank packet switch: per-source FIFOs, per-output round-robin, DONE/BAD absorption.
// Optional per-output delivery and stall counters are enabled with BANK_ROUTER_STATS_EN.
module bank_router #(
    parameter int NUM_BANKS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int DONE_TARGET = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    bank_router_if.slave                       bus,
    output logic [$clog2(DONE_TARGET+1)-1:0]   done_count,
    output logic                               all_done,
    output logic                               bad_dest
`ifdef BANK_ROUTER_STATS_EN
    ,
    output logic [NUM_BANKS-1:0][31:0]         fwd_count,
    output logic [31:0]                        stall_cycles
`endif
);
    import bank_router_pkg::*;

    localparam int NREQ = NUM_BANKS + 1;
    localparam int RW   = $clog2(NREQ);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int DW   = $clog2(DONE_TARGET + 1);

    typedef enum logic {OUT_IDLE, OUT_BUSY} out_state_t;

    pkt_t            mem       [NUM_BANKS][FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr    [NUM_BANKS];
    logic [PW-1:0]   wr_ptr    [NUM_BANKS];
    logic [CW-1:0]   fifo_cnt  [NUM_BANKS];
    out_state_t      out_state [NUM_BANKS];
    logic [RW-1:0]   grant_idx [NUM_BANKS];
    logic [RW-1:0]   rr_ptr    [NUM_BANKS];
    logic [RW-1:0]   win_idx   [NUM_BANKS];

    pkt_t            head      [NREQ];
    pkt_t            cand      [NREQ];
    logic [NREQ-1:0] head_vld, cand_vld;
    logic [NREQ-1:0] pop_out, locked, done_pop, bad_pop, pop_any;
    logic [NUM_BANKS-1:0] push, out_done, can_arb, win_vld;
    logic [DW-1:0]   done_inc;

    function automatic logic is_done(pkt_t p);
        return p.ctrl == CTRL_DONE;
    endfunction

    function automatic logic is_bad(pkt_t p);
        return (p.ctrl != CTRL_DONE) && (int'(p.addr.y) >= NUM_BANKS);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bus.from_bank_ready[i] = fifo_cnt[i] < CW'(FIFO_DEPTH);
        end
    end

    assign push     = bus.from_bank_valid & bus.from_bank_ready;
    assign out_done = bus.to_bank_valid & bus.to_bank_ready;

    always_comb begin
        for (int r = 0; r < NUM_BANKS; r++) begin
            head[r]     = mem[r][rd_ptr[r]];
            head_vld[r] = fifo_cnt[r] != '0;
        end
        head[NUM_BANKS]     = bus.host_pkt;
        head_vld[NUM_BANKS] = bus.host_valid;
    end

    // A requester is locked while an output holds its head; completing outputs release it this cycle.
    always_comb begin
        pop_out = '0;
        locked  = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (out_state[j] == OUT_BUSY && grant_idx[j] == RW'(r)) begin
                    if (out_done[j]) pop_out[r] = 1'b1;
                    else             locked[r]  = 1'b1;
                end
            end
        end
    end

    // A requester being popped offers its next entry so outputs can re-grant without a bubble.
    always_comb begin
        for (int r = 0; r < NUM_BANKS; r++) begin
            if (pop_out[r]) begin
                cand[r]     = mem[r][rd_ptr[r] + PW'(1)];
                cand_vld[r] = fifo_cnt[r] >= CW'(2);
            end else begin
                cand[r]     = head[r];
                cand_vld[r] = head_vld[r];
            end
        end
        cand[NUM_BANKS]     = head[NUM_BANKS];
        cand_vld[NUM_BANKS] = head_vld[NUM_BANKS] && !pop_out[NUM_BANKS];
    end

    always_comb begin
        logic done_found;
        logic bad_found;
        done_found = 1'b0;
        bad_found  = 1'b0;
        done_pop   = '0;
        bad_pop    = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (head_vld[r] && !locked[r] && !pop_out[r]) begin
                if (!done_found && is_done(head[r])) begin
                    done_pop[r] = 1'b1;
                    done_found  = 1'b1;
                end
                if (!bad_found && is_bad(head[r])) begin
                    bad_pop[r] = 1'b1;
                    bad_found  = 1'b1;
                end
            end
        end
    end

    assign pop_any        = pop_out | done_pop | bad_pop;
    assign bus.host_ready = pop_any[NUM_BANKS];
    assign done_inc       = done_count + 1'b1;

    always_comb begin
        int c;
        c = 0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            can_arb[j] = (out_state[j] == OUT_IDLE) || out_done[j];
            win_vld[j] = 1'b0;
            win_idx[j] = '0;
            for (int k = 0; k < NREQ; k++) begin
                c = int'(rr_ptr[j]) + k;
                if (c >= NREQ) c = c - NREQ;
                if (!win_vld[j] && cand_vld[c] && !locked[c] && !is_done(cand[c])
                    && int'(cand[c].addr.y) == j) begin
                    win_vld[j] = 1'b1;
                    win_idx[j] = RW'(c);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= bus.from_bank_pkt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                fifo_cnt[i] <= '0;
            end
            for (int j = 0; j < NUM_BANKS; j++) begin
                out_state[j]        <= OUT_IDLE;
                grant_idx[j]        <= '0;
                rr_ptr[j]           <= '0;
                bus.to_bank_valid[j] <= 1'b0;
                bus.to_bank_pkt[j]   <= '0;
            end
            done_count <= '0;
            all_done   <= 1'b0;
            bad_dest   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (push[i])    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_any[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                fifo_cnt[i] <= fifo_cnt[i] + CW'(push[i]) - CW'(pop_any[i]);
            end
            for (int j = 0; j < NUM_BANKS; j++) begin
                if (can_arb[j]) begin
                    if (win_vld[j]) begin
                        out_state[j]         <= OUT_BUSY;
                        grant_idx[j]         <= win_idx[j];
                        rr_ptr[j]            <= (win_idx[j] == RW'(NREQ - 1)) ? '0 : win_idx[j] + 1'b1;
                        bus.to_bank_valid[j] <= 1'b1;
                        bus.to_bank_pkt[j]   <= cand[win_idx[j]];
                    end else begin
                        out_state[j]         <= OUT_IDLE;
                        bus.to_bank_valid[j] <= 1'b0;
                    end
                end
            end
            bad_dest <= |bad_pop;
            if (|done_pop && done_count != DW'(DONE_TARGET)) begin
                done_count <= done_inc;
                if (done_inc == DW'(DONE_TARGET)) all_done <= 1'b1;
            end
        end
    end

`ifdef BANK_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count    <= '0;
            stall_cycles <= '0;
        end else begin
            for (int j = 0; j < NUM_BANKS; j++) begin
                if (out_done[j]) fwd_count[j] <= fwd_count[j] + 32'd1;
            end
            if (|(bus.to_bank_valid & ~bus.to_bank_ready)) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_router.sv
// Bench for bank_router: directed timing checks plus random traffic against a per-route queue model.
module tb_bank_router;
    import bank_router_pkg::*;

    localparam int NB = 4;
    localparam int FD = 4;
    localparam int DT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bank_router_if #(.NUM_BANKS(NB)) bus();
    logic [$clog2(DT+1)-1:0] done_count;
    logic all_done;
    logic bad_dest;
`ifdef BANK_ROUTER_STATS_EN
    logic [NB-1:0][31:0] fwd_count;
    logic [31:0]         stall_cycles;
`endif

    bank_router #(.NUM_BANKS(NB), .FIFO_DEPTH(FD), .DONE_TARGET(DT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .done_count (done_count),
        .all_done   (all_done),
        .bad_dest   (bad_dest)
`ifdef BANK_ROUTER_STATS_EN
        ,
        .fwd_count    (fwd_count),
        .stall_cycles (stall_cycles)
`endif
    );

    int   n_cmp = 0;
    int   n_err = 0;
    pkt_t exp_q [NB+1][NB][$];
    int   done_exp = 0;
    int   bad_exp  = 0;
    int   bad_seen = 0;
    logic mon_en   = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(int src, int y, int seq, logic done);
        pkt_t p;
        p.ctrl   = done ? CTRL_DONE : CTRL_DATA;
        p.addr.x = 4'(src);
        p.addr.y = 4'(y);
        p.addr.z = 4'($urandom_range(0, 15));
        p.data   = {4'(src), 12'(seq)};
        return p;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int s = 0; s <= NB; s++)
            for (int j = 0; j < NB; j++) n += exp_q[s][j].size();
        return n;
    endfunction

    // Scoreboard: accepted packets enter per (source, dest) queues; deliveries must match the front.
    always @(negedge clk) begin
        logic acc;
        pkt_t p;
        int   s;
        if (mon_en && !rst) begin
            for (int b = 0; b <= NB; b++) begin
                acc = (b < NB) ? (bus.from_bank_valid[b] && bus.from_bank_ready[b])
                               : (bus.host_valid && bus.host_ready);
                p   = (b < NB) ? bus.from_bank_pkt[b] : bus.host_pkt;
                if (acc) begin
                    if (p.ctrl == CTRL_DONE)         done_exp++;
                    else if (int'(p.addr.y) >= NB)   bad_exp++;
                    else                             exp_q[b][p.addr.y].push_back(p);
                end
            end
            if (bad_dest) bad_seen++;
            for (int j = 0; j < NB; j++) begin
                if (bus.to_bank_valid[j] && bus.to_bank_ready[j]) begin
                    p = bus.to_bank_pkt[j];
                    s = int'(p.data[15:12]);
                    if (s <= NB && exp_q[s][j].size() != 0)
                        check_val("deliver_pkt", 64'(p), 64'(exp_q[s][j].pop_front()));
                    else
                        check_val("deliver_expected", 64'(s), 64'(NB + 1));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t p, first;
        int   acc;
        logic took;
        logic [NB:0] tk;
        int   seq [NB+1];
        int   r;
        logic drained;

        rst = 1'b1;
        bus.from_bank_valid = '0;
        bus.from_bank_pkt   = '0;
        bus.to_bank_ready   = '1;
        bus.host_valid      = 1'b0;
        bus.host_pkt        = '0;
        for (int b = 0; b <= NB; b++) seq[b] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset and idle
        for (int c = 0; c < 10; c++) begin
            tick();
            check_val("idle_to_valid", 64'(bus.to_bank_valid), 64'(0));
            check_val("idle_from_ready", 64'(bus.from_bank_ready), 64'(4'hF));
            check_val("idle_host_ready", 64'(bus.host_ready), 64'(0));
            check_val("idle_all_done", 64'(all_done), 64'(0));
        end
        check_val("idle_done_count", 64'(done_count), 64'(0));
        check_val("idle_bad_dest", 64'(bad_dest), 64'(0));
        check_val("idle_to_pkt", 64'(bus.to_bank_pkt), 64'(0));

        // Host injection to bank 2
        p = mk(NB, 2, 0, 1'b0);
        bus.host_pkt   = p;
        bus.host_valid = 1'b1;
        tick();
        check_val("host_to_valid", 64'(bus.to_bank_valid), 64'(4'b0100));
        check_val("host_to_pkt", 64'(bus.to_bank_pkt[2]), 64'(p));
        check_val("host_ready", 64'(bus.host_ready), 64'(1));
        tick();
        bus.host_valid = 1'b0;
        check_val("host_after", 64'(bus.to_bank_valid), 64'(0));

        // Contention on output 2 from banks 0,1,3, two rounds
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int b = 0; b < NB; b++) bus.from_bank_pkt[b] = mk(b, 2, 10 + rnd, 1'b0);
            bus.from_bank_valid = 4'b1011;
            tick();
            bus.from_bank_valid = '0;
            for (int k = 0; k < 3; k++) begin
                tick();
                check_val("rr_valid", 64'(bus.to_bank_valid), 64'(4'b0100));
                check_val("rr_src", 64'(bus.to_bank_pkt[2].data[15:12]), 64'((k == 2) ? 3 : k));
            end
            tick();
            check_val("rr_idle", 64'(bus.to_bank_valid), 64'(0));
        end

        // Back-pressure on output 1 while bank 0 streams
        bus.to_bank_ready = 4'b1101;
        first = mk(0, 1, 100, 1'b0);
        bus.from_bank_pkt[0]   = first;
        bus.from_bank_valid[0] = 1'b1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            took = bus.from_bank_ready[0];
            tick();
            if (took) begin
                acc++;
                bus.from_bank_pkt[0] = mk(0, 1, 100 + acc, 1'b0);
            end
        end
        bus.from_bank_valid[0] = 1'b0;
        check_val("bp_accepts", 64'(acc), 64'(FD));
        check_val("bp_from_ready", 64'(bus.from_bank_ready[0]), 64'(0));
        check_val("bp_valid", 64'(bus.to_bank_valid), 64'(4'b0010));
        check_val("bp_held_pkt", 64'(bus.to_bank_pkt[1]), 64'(first));
        bus.to_bank_ready = '1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            check_val("bp_drain_valid", 64'(bus.to_bank_valid[1]), 64'(1));
            check_val("bp_drain_seq", 64'(bus.to_bank_pkt[1].data[11:0]), 64'(100 + k));
        end
        tick();
        check_val("bp_drain_end", 64'(bus.to_bank_valid), 64'(0));

        // CTRL_DONE absorption
        bus.from_bank_pkt[3]   = mk(3, 0, 200, 1'b1);
        bus.from_bank_valid[3] = 1'b1;
        tick();
        bus.from_bank_valid[3] = 1'b0;
        check_val("done_before", 64'(done_count), 64'(0));
        tick();
        check_val("done_count", 64'(done_count), 64'(1));
        check_val("done_all", 64'(all_done), 64'(1));
        check_val("done_no_out", 64'(bus.to_bank_valid), 64'(0));
        bus.from_bank_pkt[1]   = mk(1, 2, 201, 1'b1);
        bus.from_bank_valid[1] = 1'b1;
        tick();
        bus.from_bank_valid[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("done_hold", 64'(all_done), 64'(1));
            check_val("done_sat", 64'(done_count), 64'(DT));
        end

        // Bad destination drop, then FIFO 0 proves empty with a fresh packet
        bus.from_bank_pkt[0]   = mk(0, 7, 300, 1'b0);
        bus.from_bank_valid[0] = 1'b1;
        tick();
        bus.from_bank_valid[0] = 1'b0;
        check_val("bad_early", 64'(bad_dest), 64'(0));
        tick();
        check_val("bad_pulse", 64'(bad_dest), 64'(1));
        check_val("bad_no_out", 64'(bus.to_bank_valid), 64'(0));
        p = mk(0, 0, 301, 1'b0);
        bus.from_bank_pkt[0]   = p;
        bus.from_bank_valid[0] = 1'b1;
        tick();
        bus.from_bank_valid[0] = 1'b0;
        check_val("bad_pulse_end", 64'(bad_dest), 64'(0));
        check_val("bad_fifo_ready", 64'(bus.from_bank_ready), 64'(4'hF));
        tick();
        check_val("after_bad_valid", 64'(bus.to_bank_valid), 64'(4'b0001));
        check_val("after_bad_pkt", 64'(bus.to_bank_pkt[0]), 64'(p));
        tick();

        // Random traffic, loopback included
        for (int b = 0; b <= NB; b++) seq[b] = 400;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) tk[b] = bus.from_bank_valid[b] && bus.from_bank_ready[b];
            tk[NB] = bus.host_valid && bus.host_ready;
            tick();
            for (int b = 0; b <= NB; b++) begin
                if ((b < NB && (!bus.from_bank_valid[b] || tk[b])) ||
                    (b == NB && (!bus.host_valid || tk[b]))) begin
                    r = $urandom_range(0, 99);
                    if (r < 4)      p = mk(b, $urandom_range(0, NB - 1), seq[b], 1'b1);
                    else if (r < 8) p = mk(b, $urandom_range(NB, 15), seq[b], 1'b0);
                    else            p = mk(b, $urandom_range(0, NB - 1), seq[b], 1'b0);
                    seq[b]++;
                    if (b < NB) begin
                        bus.from_bank_pkt[b]   = p;
                        bus.from_bank_valid[b] = ($urandom_range(0, 99) < 50);
                    end else begin
                        bus.host_pkt   = p;
                        bus.host_valid = ($urandom_range(0, 99) < 8);
                    end
                end
            end
            for (int j = 0; j < NB; j++) bus.to_bank_ready[j] = ($urandom_range(0, 3) != 0);
        end

        // Drain: hold offers until accepted, no new traffic
        bus.to_bank_ready = '1;
        drained = 1'b0;
        for (int c = 0; c < 300 && !drained; c++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) tk[b] = bus.from_bank_valid[b] && bus.from_bank_ready[b];
            tk[NB] = bus.host_valid && bus.host_ready;
            tick();
            for (int b = 0; b < NB; b++) if (tk[b]) bus.from_bank_valid[b] = 1'b0;
            if (tk[NB]) bus.host_valid = 1'b0;
            drained = (bus.from_bank_valid == '0) && !bus.host_valid && (pending() == 0)
                      && (bus.to_bank_valid == '0);
        end
        repeat (10) tick();
        check_val("drain_done", 64'(drained), 64'(1));
        check_val("drain_pending", 64'(pending()), 64'(0));
        check_val("drain_bad_count", 64'(bad_seen), 64'(bad_exp));
        check_val("drain_done_count", 64'(done_count), 64'((done_exp >= DT) ? DT : done_exp));
        check_val("drain_all_done", 64'(all_done), 64'(done_exp >= DT));
        check_val("drain_from_ready", 64'(bus.from_bank_ready), 64'(4'hF));

        // Reset in the middle of queued traffic
        bus.to_bank_ready = '0;
        for (int c = 0; c < 12; c++) begin
            for (int b = 0; b < NB; b++) bus.from_bank_pkt[b] = mk(b, $urandom_range(0, NB - 1), 900 + c, 1'b0);
            bus.from_bank_valid = '1;
            tick();
        end
        mon_en = 1'b0;
        rst = 1'b1;
        bus.from_bank_valid = '0;
        tick();
        rst = 1'b0;
        for (int s = 0; s <= NB; s++)
            for (int j = 0; j < NB; j++) exp_q[s][j].delete();
        done_exp = 0;
        check_val("rst_to_valid", 64'(bus.to_bank_valid), 64'(0));
        check_val("rst_to_pkt", 64'(bus.to_bank_pkt), 64'(0));
        check_val("rst_from_ready", 64'(bus.from_bank_ready), 64'(4'hF));
        check_val("rst_done_count", 64'(done_count), 64'(0));
        check_val("rst_all_done", 64'(all_done), 64'(0));
        mon_en = 1'b1;
        bus.to_bank_ready = '1;
        p = mk(2, 3, 999, 1'b0);
        bus.from_bank_pkt[2]   = p;
        bus.from_bank_valid[2] = 1'b1;
        tick();
        bus.from_bank_valid[2] = 1'b0;
        tick();
        check_val("rst_after_valid", 64'(bus.to_bank_valid), 64'(4'b1000));
        check_val("rst_after_pkt", 64'(bus.to_bank_pkt[3]), 64'(p));
        repeat (3) tick();
        check_val("rst_after_pending", 64'(pending()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bank_router.md
Name: bank_router

Overview:
- Central packet switch facing all banks; it is the far end of each bank's router_valid/ready/pkt interface.
- It accepts packets leaving each bank, queues them per source, and delivers them to the destination bank selected by pkt.addr.y; pkt.addr.z is untouched and is resolved inside the bank.
- It absorbs CTRL_DONE packets and raises a global completion flag.
- It also provides a host injection port for seeding the first packet.

Parameters:
- NUM_BANKS, 4, number of bank ports; addr.y values 0..NUM_BANKS-1 are valid.
- FIFO_DEPTH, 4, entries per source input FIFO; power of two, at least 2.
- DONE_TARGET, 1, number of CTRL_DONE packets required to assert all_done.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- from_bank_valid  in  NUM_BANKS  packet offered by bank i (connects to bank router_valid_out).
- from_bank_ready  out  NUM_BANKS  router accepts from bank i (connects to bank router_ready_out).
- from_bank_pkt  in  pkt_t x NUM_BANKS  packet from bank i.
- to_bank_valid  out  NUM_BANKS  packet offered to bank j (connects to bank router_valid_in).
- to_bank_ready  in  NUM_BANKS  bank j accepts (connects to bank router_ready_in).
- to_bank_pkt  out  pkt_t x NUM_BANKS  packet to bank j.
- host_valid  in  1  host injection valid.
- host_ready  out  1  host injection accepted.
- host_pkt  in  pkt_t  host packet.
- done_count  out  $clog2(DONE_TARGET+1)  CTRL_DONE packets absorbed, saturating at DONE_TARGET.
- all_done  out  1  sticky; set once done_count equals DONE_TARGET.
- bad_dest  out  1  one-cycle pulse when a packet with addr.y >= NUM_BANKS is dropped.

Behaviour:
- Reset (synchronous, active-high): FIFOs empty, RR pointers 0, done_count 0, all_done 0, bad_dest 0, to_bank_valid 0, to_bank_pkt 0, from_bank_ready reflects empty FIFOs (all 1s) from the first cycle after reset. Reset mid-transfer discards all queued and in-flight packets.
- Input side:
  - from_bank_ready[i] = (FIFO i count < FIFO_DEPTH), computed from registered count only. It never depends on valid.
  - Push occurs on valid&&ready. A pop in the same cycle never enables a push on a full FIFO.
- Host port:
  - Requester index NUM_BANKS in arbitration; it has no FIFO.
  - host_ready = 1 only in a cycle where host_pkt is granted and its transfer completes.
- Head classification, per requester head:
  - ctrl==CTRL_DONE: DONE class.
  - addr.y >= NUM_BANKS: BAD class.
  - otherwise: routed to output addr.y.
- DONE unit:
  - Pops at most one DONE head per cycle, lowest requester index wins.
  - done_count increments, saturating.
  - all_done is set when the post-increment count equals DONE_TARGET and holds until rst.
- BAD heads:
  - Popped immediately; lowest index, one per cycle.
  - bad_dest pulses for 1 cycle.
- Output arbitration, per output j:
  - Round-robin over requesters 0..NUM_BANKS whose head routes to j.
  - State: IDLE -> BUSY on grant. Grant is locked while BUSY, so to_bank_pkt and to_bank_valid stay stable until to_bank_ready.
  - BUSY -> IDLE on valid&&ready; the requester's FIFO is popped in that cycle.
  - The RR pointer then moves to winner+1 mod (NUM_BANKS+1).
  - A requester is granted to at most one output at a time; its head has only one destination.
- to_bank_valid/to_bank_pkt are registered outputs.
- Latency: packet pushed in cycle t is offered at to_bank earliest in cycle t+2 (write in t, grant in t+1, registered output in t+2).
- Throughput: each output sustains 1 packet/cycle with back-to-back grants, by re-arbitrating in the completing cycle.
- Loopback (source bank == destination bank) is legal and handled like any other route.
- Ordering: packets from the same source to the same destination are delivered in FIFO order.

Optional Feature:
- Macro: BANK_ROUTER_STATS_EN.
- When defined, extra outputs are added:
  - fwd_count (32 bits x NUM_BANKS): packets delivered per output, incremented on each to_bank valid&&ready.
  - stall_cycles (32 bits): cycles where any output is valid && !ready.
  - All counters wrap and are cleared by rst.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: all to_bank_valid=0, from_bank_ready=4'b1111, host_ready=0, all_done=0 for 10 cycles.
- Host injects pkt addr.y=2 at cycle 5 -> to_bank_valid[2]=1 with identical pkt by cycle 7; no other output valid.
- Banks 0,1,3 each push one pkt to addr.y=2 in the same cycle, to_bank_ready[2]=1 -> delivered on consecutive cycles in order 0,1,3; next contention round starts at 0 again after pointer wraps past 4.
- to_bank_ready[1]=0 for 20 cycles while bank 0 streams to addr.y=1 -> from_bank_ready[0] drops after 4 accepts (FIFO_DEPTH=4) and the held to_bank_pkt is unchanged; the 4 accepted pkts drain in order after ready returns.
- Bank 3 sends a CTRL_DONE pkt (DONE_TARGET=1) -> done_count=1 and all_done=1 next cycle; no to_bank_valid; all_done holds until rst.
- Bank 0 sends a pkt with addr.y=7 -> single-cycle bad_dest pulse, pkt dropped, FIFO 0 empty afterward.
